adder_seq: RTL

- Parametrised multi-cycle adder/subtractor. It is the next generation of the team's 6-bit ripple full-adder chain.
- Operands are latched on a start handshake. One CHUNK-bit slice is added per clock, low slice first, with the carry held in a register between slices.
- Produces a WIDTH+1 result (MSB = carry out), a signed-overflow flag and a one-cycle done pulse.
- Used where a wide combinational ripple chain would violate timing and the extra cycles of latency are acceptable.

---
 rtl/adder_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/adder_seq.sv
// adder_seq: multi-cycle adder/subtractor, one CHUNK-bit slice per clock.
// Carry is registered between slices; done pulses for one cycle with the result.
module adder_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] sa, sb, s;
  logic             c;
  logic             last;

  // Slice mux over constant part-selects keeps index widths exact.
  always_comb begin
    sa = '0;
    sb = '0;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IW'(k)) begin
        sa = a_q[k*CHUNK +: CHUNK];
        sb = b_q[k*CHUNK +: CHUNK];
      end
    end
    {c, s} = {1'b0, sa} + {1'b0, sb}
           + {{CHUNK{1'b0}}, carry_q};
    last = (idx_q == IW'(N - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub | c_in;
          sum_d   = '0;
          ovf_d   = 1'b0;
          idx_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int k = 0; k < N; k++) begin
          if (idx_q == IW'(k)) begin
            sum_d[k*CHUNK +: CHUNK] = s;
          end
        end
        carry_d = c;
        if (last) begin
          sum_d[WIDTH] = c;
          ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1])
               && (s[CHUNK-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule
